// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types for the reservation station: the renamed op from dispatch and the
// stored RS entry, which is that op plus its operand-ready flags.
package rs_issue_scheduler_pkg;

    localparam int RS_ENTRIES = 8;
    localparam int RS_PTAG_W  = 6;
    localparam logic [RS_PTAG_W-1:0] PTAG_ZERO = 6'd0;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
        ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI
    } alu_op_t;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          imm;
        alu_op_t              alu_op;
        logic                 alu_src;
        logic                 mem_read;
        logic                 mem_write;
        logic [RS_PTAG_W-1:0] rs1_p;
        logic [RS_PTAG_W-1:0] rs2_p;
        logic [RS_PTAG_W-1:0] rd_p;
        logic [3:0]           rob_tag;
    } rs_issue_packet_t;

    typedef struct packed {
        rs_issue_packet_t pkt;
        logic             src1_ready;
        logic             src2_ready;
    } rs_entry_t;

endpackage

// File: rtl/rs_issue_scheduler_age.sv
// Age matrix: older_q[i][j] = 1 means slot i was allocated before slot j.
// Produces a one-hot grant for the oldest requesting slot.
module rs_issue_scheduler_age #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 alloc_i,
    input  logic [$clog2(N)-1:0] alloc_idx_i,
    input  logic                 free_i,
    input  logic [$clog2(N)-1:0] free_idx_i,
    input  logic [N-1:0]         live_i,
    input  logic [N-1:0]         req_i,
    output logic [N-1:0]         grant_o
);

    logic [N-1:0] older_q [N];
    logic [N-1:0] older_d [N];

    always_comb begin
        older_d = older_q;
        if (free_i) begin
            for (int k = 0; k < N; k++) begin
                older_d[free_idx_i][k] = 1'b0;
                older_d[k][free_idx_i] = 1'b0;
            end
        end
        // A new slot is younger than everything still live after this edge.
        if (alloc_i) begin
            for (int k = 0; k < N; k++) begin
                older_d[k][alloc_idx_i] = live_i[k];
                older_d[alloc_idx_i][k] = 1'b0;
            end
        end
        if (clear_i) begin
            for (int k = 0; k < N; k++) older_d[k] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) older_q[k] <= '0;
        end else begin
            older_q <= older_d;
        end
    end

    always_comb begin
        grant_o = '0;
        for (int i = 0; i < N; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (req_i[j] && older_q[j][i]) blocked = 1'b1;
            end
            grant_o[i] = req_i[i] && !blocked;
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation station for one FU: buffers renamed ops, wakes operands from the CDB
// and issues the oldest fully-ready entry over a valid/ready handshake.
module rs_issue_scheduler
    import rs_issue_scheduler_pkg::*;
#(
    parameter int N_ENTRIES = RS_ENTRIES,
    parameter int PTAG_W    = RS_PTAG_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  rs_issue_packet_t             disp_pkt,
    input  logic                         disp_src1_rdy,
    input  logic                         disp_src2_rdy,
    input  logic                         cdb_valid,
    input  logic [PTAG_W-1:0]            cdb_tag,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output rs_entry_t                    issue_entry,
    output logic [$clog2(N_ENTRIES):0]   free_count
);

    localparam int IDX_W = $clog2(N_ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    logic [N_ENTRIES-1:0] valid_q, valid_d;
    rs_entry_t            entries_q [N_ENTRIES];
    rs_entry_t            entries_d [N_ENTRIES];

    logic [N_ENTRIES-1:0] cand, grant, live;
    logic [IDX_W-1:0]     alloc_idx, sel_idx;
    logic                 disp_fire, issue_fire;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_ENTRIES-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_ENTRIES; i++) cnt = cnt + CNT_W'(v[i]);
        return cnt;
    endfunction

    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_ENTRIES-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_ENTRIES-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (v[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

    always_comb begin
        free_count = CNT_W'(N_ENTRIES) - popcount(valid_q);
        disp_ready = |(~valid_q);
        alloc_idx  = lowest_set(~valid_q);
        disp_fire  = disp_valid && disp_ready && !flush;

        for (int i = 0; i < N_ENTRIES; i++) begin
            cand[i] = valid_q[i] && entries_q[i].src1_ready && entries_q[i].src2_ready;
        end
        issue_valid = |cand;
        sel_idx     = onehot_to_idx(grant);
        issue_entry = entries_q[sel_idx];
        issue_fire  = issue_valid && issue_ready && !flush;

        live = valid_q;
        if (issue_fire) live = live & ~grant;
    end

    rs_issue_scheduler_age #(.N(N_ENTRIES)) u_age (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (flush),
        .alloc_i     (disp_fire),
        .alloc_idx_i (alloc_idx),
        .free_i      (issue_fire),
        .free_idx_i  (sel_idx),
        .live_i      (live),
        .req_i       (cand),
        .grant_o     (grant)
    );

    always_comb begin
        valid_d   = valid_q;
        entries_d = entries_q;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (valid_q[i] && cdb_valid) begin
                if (cdb_tag == entries_q[i].pkt.rs1_p) entries_d[i].src1_ready = 1'b1;
                if (cdb_tag == entries_q[i].pkt.rs2_p) entries_d[i].src2_ready = 1'b1;
            end
        end
        if (issue_fire) valid_d[sel_idx] = 1'b0;
        // Ready flags captured at dispatch also see a same-cycle CDB broadcast.
        if (disp_fire) begin
            valid_d[alloc_idx]            = 1'b1;
            entries_d[alloc_idx].pkt      = disp_pkt;
            entries_d[alloc_idx].src1_ready = disp_src1_rdy || (disp_pkt.rs1_p == PTAG_ZERO) ||
                                              (cdb_valid && cdb_tag == disp_pkt.rs1_p);
            entries_d[alloc_idx].src2_ready = disp_src2_rdy || disp_pkt.alu_src ||
                                              (disp_pkt.rs2_p == PTAG_ZERO) ||
                                              (cdb_valid && cdb_tag == disp_pkt.rs2_p);
        end
        if (flush) valid_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(disp_fire && valid_q[alloc_idx]));
            assert (free_count <= CNT_W'(N_ENTRIES));
        end
    end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Scoreboard bench for rs_issue_scheduler: expected issue order (and cycle where it matters)
// is queued when ops are dispatched and checked on each issue handshake.
module tb_rs_issue_scheduler;
    import rs_issue_scheduler_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n, flush, disp_valid, disp_ready;
    rs_issue_packet_t disp_pkt;
    logic             disp_src1_rdy, disp_src2_rdy, cdb_valid;
    logic [5:0]       cdb_tag;
    logic             issue_valid, issue_ready;
    rs_entry_t        issue_entry;
    logic [3:0]       free_count;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    rs_issue_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_pkt      (disp_pkt),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_src2_rdy (disp_src2_rdy),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_entry   (issue_entry),
        .free_count    (free_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Issue monitor, sampled on the falling edge while inputs are stable.
    always @(negedge clk) begin
        if (rst_n && !flush && issue_valid && issue_ready) begin
            if (sb.size() == 0) begin
                check_val("unexp_issue", 64'(issue_entry.pkt.pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("issue_pc", 64'(issue_entry.pkt.pc), 64'(e.pc));
                check_val("issue_rdy", 64'({issue_entry.src1_ready, issue_entry.src2_ready}), 64'(2'b11));
                if (e.cyc >= 0) check_val("issue_cyc", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        cdb_tag    = '0;
        flush      = 1'b0;
    endtask

    task automatic set_disp(input logic [31:0] pc, input logic [5:0] rs1, input logic [5:0] rs2,
                            input logic r1, input logic r2, input logic imm_src);
        disp_pkt         = '0;
        disp_pkt.pc      = pc;
        disp_pkt.rs1_p   = rs1;
        disp_pkt.rs2_p   = rs2;
        disp_pkt.rd_p    = 6'd40;
        disp_pkt.alu_src = imm_src;
        disp_src1_rdy    = r1;
        disp_src2_rdy    = r2;
        disp_valid       = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
        check_val(tag, 64'(sb.size()), 64'd0);
        idle();
        tick();
    endtask

    initial begin
        int acc;
        logic acc_now;
        rst_n = 1'b0; issue_ready = 1'b0; disp_pkt = '0;
        disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
        idle();
        tick(); tick();
        check_val("rst_disp_ready", 64'(disp_ready), 64'd1);
        check_val("rst_issue_valid", 64'(issue_valid), 64'd0);
        check_val("rst_free_count", 64'(free_count), 64'd8);
        rst_n = 1'b1;
        tick();

        // Fill all 8 slots with ready ops while the FU stalls.
        for (int i = 0; i < 8; i++) begin
            set_disp(32'h100 + 32'(4 * i), 6'd1, 6'd2, 1'b1, 1'b1, 1'b0);
            sb.push_back('{pc: 32'h100 + 32'(4 * i), cyc: -1});
            tick();
        end
        idle();
        check_val("full_disp_ready", 64'(disp_ready), 64'd0);
        check_val("full_free_count", 64'(free_count), 64'd0);
        check_val("full_issue_valid", 64'(issue_valid), 64'd1);
        check_val("full_oldest_pc", 64'(issue_entry.pkt.pc), 64'h100);
        set_disp(32'hDEAD, 6'd1, 6'd2, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        check_val("full_ignored", 64'(free_count), 64'd0);
        issue_ready = 1'b1;
        drain("drain_full");
        check_val("empty_free_count", 64'(free_count), 64'd8);
        check_val("empty_issue_valid", 64'(issue_valid), 64'd0);

        // Out-of-order wakeup: A waits on tag 12, B is ready.
        sb.push_back('{pc: 32'hB00, cyc: cyc + 2});
        sb.push_back('{pc: 32'hA00, cyc: cyc + 4});
        set_disp(32'hA00, 6'd12, 6'd3, 1'b0, 1'b1, 1'b0);
        tick();
        set_disp(32'hB00, 6'd4, 6'd5, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        cdb_valid = 1'b1; cdb_tag = 6'd12;
        tick();
        idle();
        drain("drain_wakeup");

        // Immediate operand: busy rs2 is not waited on.
        sb.push_back('{pc: 32'hC00, cyc: cyc + 1});
        set_disp(32'hC00, 6'd4, 6'd20, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        drain("drain_imm");

        // Same-cycle CDB match on the dispatching op.
        sb.push_back('{pc: 32'hD00, cyc: cyc + 1});
        set_disp(32'hD00, 6'd7, 6'd4, 1'b0, 1'b1, 1'b0);
        cdb_valid = 1'b1; cdb_tag = 6'd7;
        tick();
        idle();
        drain("drain_bypass");

        // Physical register zero is always ready.
        sb.push_back('{pc: 32'hE00, cyc: cyc + 1});
        set_disp(32'hE00, 6'd0, 6'd4, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        drain("drain_p0");

        // Full RS streaming: issue and dispatch overlap every cycle.
        issue_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_disp(32'h200 + 32'(4 * i), 6'd1, 6'd2, 1'b1, 1'b1, 1'b0);
            sb.push_back('{pc: 32'h200 + 32'(4 * i), cyc: -1});
            tick();
        end
        issue_ready = 1'b1;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            set_disp(32'h300 + 32'(4 * acc), 6'd1, 6'd2, 1'b1, 1'b1, 1'b0);
            acc_now = disp_ready;
            check_val("stream_issue_valid", 64'(issue_valid), 64'd1);
            if (k > 0) check_val("stream_free_count", 64'(free_count), 64'd1);
            tick();
            if (acc_now) begin
                sb.push_back('{pc: 32'h300 + 32'(4 * acc), cyc: -1});
                acc++;
            end
        end
        check_val("stream_accepts", 64'(acc), 64'd9);
        idle();
        drain("drain_stream");

        // Flush beats dispatch and wakeup in the same cycle.
        issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_disp(32'h600 + 32'(4 * i), 6'd30, 6'd2, 1'b0, 1'b1, 1'b0);
            tick();
        end
        idle();
        check_val("pre_flush_free", 64'(free_count), 64'd3);
        set_disp(32'hF00, 6'd1, 6'd2, 1'b1, 1'b1, 1'b0);
        cdb_valid = 1'b1; cdb_tag = 6'd30; flush = 1'b1;
        tick();
        idle();
        check_val("flush_free_count", 64'(free_count), 64'd8);
        check_val("flush_issue_valid", 64'(issue_valid), 64'd0);
        check_val("flush_disp_ready", 64'(disp_ready), 64'd1);
        issue_ready = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 6'd30;
        tick();
        idle();
        repeat (3) tick();

        // Reset in the middle of operation discards held entries.
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_disp(32'h700 + 32'(4 * i), 6'd1, 6'd2, 1'b1, 1'b1, 1'b0);
            tick();
        end
        idle();
        check_val("pre_rst_free", 64'(free_count), 64'd5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_val("midrst_free_count", 64'(free_count), 64'd8);
        check_val("midrst_issue_valid", 64'(issue_valid), 64'd0);
        issue_ready = 1'b1;
        repeat (3) tick();
        check_val("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
